// File: rtl/cancid_ctx_pkg.sv
// Shared types for the per-stream DFA context matcher: default widths, packet FSM states
// and a saturating increment helper.
package cancid_ctx_pkg;

  localparam int STATE_W_DEF = 11;
  localparam int SID_W_DEF   = 6;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    COMMIT = 3'd4
  } ctx_state_e;

  // Adds inc to val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (inc && (val != max_val)) ? val + 32'd1 : val;
  endfunction

endpackage

// File: rtl/cancid_ctx_engine.sv
// HTTP-category DFA engine: detects "HTTP" one byte per cycle; the state register can be
// overwritten through state_in/state_in_vld to resume a saved stream context.
module cancid_ctx_engine
  import cancid_ctx_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic [STATE_W-1:0] state_in,
  input  logic               state_in_vld,
  output logic [STATE_W-1:0] state_out,
  output logic               accept_out
);

  localparam logic [STATE_W-1:0] S_ACCEPT = STATE_W'(4);

  logic [STATE_W-1:0] state_q, state_d;
  logic               accept_q, accept_d;

  // The accept state behaves like the start state, so matches restart after a hit.
  function automatic logic [STATE_W-1:0] http_step(input logic [STATE_W-1:0] s,
                                                   input logic [7:0] c);
    logic [STATE_W-1:0] base;
    logic [7:0]         want;
    base = (s > STATE_W'(3)) ? '0 : s;
    case (base)
      STATE_W'(0): want = 8'h48;
      STATE_W'(1): want = 8'h54;
      STATE_W'(2): want = 8'h54;
      default:     want = 8'h50;
    endcase
    if (c == want)       return base + STATE_W'(1);
    else if (c == 8'h48) return STATE_W'(1);
    else                 return '0;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    accept_d = 1'b0;
    if (state_in_vld) begin
      state_d = state_in;
    end else if (char_in_vld) begin
      state_d  = http_step(state_q, char_in);
      accept_d = (state_d == S_ACCEPT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      accept_q <= accept_d;
    end
  end

  assign state_out  = state_q;
  assign accept_out = accept_q;

endmodule

// File: rtl/cancid_stream_ctx_matcher.sv
// Per-stream context wrapper around the DFA engine: packet FSM, context save/restore, hit
// counters and protocol-error flag. Define CANCID_PER_STREAM_CNT_EN for per-stream counters.
module cancid_stream_ctx_matcher
  import cancid_ctx_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF,
  parameter int SID_W   = SID_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sop,
  input  logic [SID_W-1:0] stream_id,
  input  logic             new_stream,
  input  logic             enable,
  input  logic [7:0]       char_in,
  input  logic             char_vld,
  input  logic             eop,
  output logic             in_ready,
  output logic             pkt_done,
  output logic             fired,
  output logic [CNT_W-1:0] count,
  output logic             proto_err,
  input  logic [SID_W-1:0] rd_sid,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam int DEPTH = 1 << SID_W;

  ctx_state_e         st_q, st_d;
  logic [SID_W-1:0]   sid_q, sid_d;
  logic               new_q, new_d, en_q, en_d, hit_q, hit_d;
  logic               fired_q, fired_d, err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic               mem_we;
  logic [STATE_W-1:0] ctx_mem [DEPTH];
  logic [STATE_W-1:0] mem_rdata_q;
  logic [STATE_W-1:0] eng_state_in, eng_state_out;
  logic               eng_accept;

  // Stored context is only trusted when the stream has committed at least once.
  assign eng_state_in = (new_q || !valid_q[sid_q]) ? '0 : mem_rdata_q;

  cancid_ctx_engine #(.STATE_W(STATE_W)) u_engine (
    .clk          (clk),
    .rst_n        (rst_n),
    .char_in      (char_in),
    .char_in_vld  (char_vld && (st_q == RUN)),
    .state_in     (eng_state_in),
    .state_in_vld (st_q == LOAD),
    .state_out    (eng_state_out),
    .accept_out   (eng_accept)
  );

  always_comb begin
    st_d     = st_q;
    sid_d    = sid_q;
    new_d    = new_q;
    en_d     = en_q;
    hit_d    = hit_q;
    fired_d  = fired_q;
    err_d    = err_q;
    count_d  = count_q;
    valid_d  = valid_q;
    mem_we   = 1'b0;
    pkt_done = 1'b0;
    case (st_q)
      IDLE: begin
        if (char_vld || eop) err_d = 1'b1;
        if (sop) begin
          sid_d   = stream_id;
          new_d   = new_stream;
          en_d    = enable;
          hit_d   = 1'b0;
          fired_d = 1'b0;
          st_d    = LOAD;
        end
      end
      LOAD: st_d = RUN;
      RUN: begin
        if (sop) err_d = 1'b1;
        if (eng_accept) hit_d = 1'b1;
        if (eop) st_d = DRAIN;
      end
      DRAIN: begin
        if (eng_accept) hit_d = 1'b1;
        st_d = COMMIT;
      end
      COMMIT: begin
        pkt_done = 1'b1;
        st_d     = IDLE;
        fired_d  = en_q && hit_q;
        if (en_q) begin
          mem_we         = 1'b1;
          valid_d[sid_q] = 1'b1;
          count_d        = CNT_W'(sat_inc(32'(count_q), hit_q, CNT_W));
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      sid_q   <= '0;
      new_q   <= 1'b0;
      en_q    <= 1'b0;
      hit_q   <= 1'b0;
      fired_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      st_q    <= st_d;
      sid_q   <= sid_d;
      new_q   <= new_d;
      en_q    <= en_d;
      hit_q   <= hit_d;
      fired_q <= fired_d;
      err_q   <= err_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: the context RAM has no reset; the valid flops decide whether its contents are used.
  always_ff @(posedge clk) begin
    if (mem_we) ctx_mem[sid_q] <= eng_state_out;
    mem_rdata_q <= ctx_mem[stream_id];
  end

  assign in_ready  = (st_q == IDLE) || (st_q == RUN);
  assign fired     = (st_q == COMMIT) ? fired_d : fired_q;
  assign count     = count_q;
  assign proto_err = err_q;

`ifdef CANCID_PER_STREAM_CNT_EN
  logic [DEPTH-1:0][CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]            rd_cnt_q, rd_cnt_d;

  always_comb begin
    scnt_d   = scnt_q;
    rd_cnt_d = scnt_q[rd_sid];
    if ((st_q == LOAD) && new_q) scnt_d[sid_q] = '0;
    if ((st_q == COMMIT) && en_q)
      scnt_d[sid_q] = CNT_W'(sat_inc(32'(scnt_q[sid_q]), hit_q, CNT_W));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scnt_q   <= '0;
      rd_cnt_q <= '0;
    end else begin
      scnt_q   <= scnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
`else
  logic unused_rd_sid;
  assign unused_rd_sid = ^rd_sid;
  assign rd_cnt        = '0;
`endif

endmodule

// File: tb/tb_cancid_stream_ctx_matcher.sv
// Bench for cancid_stream_ctx_matcher: directed packet table, protocol/reset sequences and
// random packets against a string-search reference model; a CNT_W=2 twin exercises saturation.
module tb_cancid_stream_ctx_matcher;

  localparam int SID_W = 6;
  localparam int CNT_W = 16;
  localparam int NSID  = 1 << SID_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sop = 1'b0, new_stream = 1'b0, enable = 1'b0, char_vld = 1'b0, eop = 1'b0;
  logic [SID_W-1:0] stream_id = '0, rd_sid = '0;
  logic [7:0]       char_in = '0;
  logic             in_ready, pkt_done, fired, proto_err;
  logic [CNT_W-1:0] count, rd_cnt;
  logic             s_in_ready, s_pkt_done, s_fired, s_proto_err;
  logic [1:0]       s_count, s_rd_cnt;

  cancid_stream_ctx_matcher #(.STATE_W(11), .SID_W(SID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .sop(sop), .stream_id(stream_id), .new_stream(new_stream),
    .enable(enable), .char_in(char_in), .char_vld(char_vld), .eop(eop), .in_ready(in_ready),
    .pkt_done(pkt_done), .fired(fired), .count(count), .proto_err(proto_err),
    .rd_sid(rd_sid), .rd_cnt(rd_cnt)
  );

  cancid_stream_ctx_matcher #(.STATE_W(11), .SID_W(SID_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sop(sop), .stream_id(stream_id), .new_stream(new_stream),
    .enable(enable), .char_in(char_in), .char_vld(char_vld), .eop(eop), .in_ready(s_in_ready),
    .pkt_done(s_pkt_done), .fired(s_fired), .count(s_count), .proto_err(s_proto_err),
    .rd_sid(rd_sid), .rd_cnt(s_rd_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: per-stream text tail, firing totals, per-stream counts, error flag.
  string       hist   [NSID];
  bit          hvalid [NSID];
  int unsigned m_fires;
  int unsigned m_scnt [NSID];
  bit          m_err;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    int    sid;
    bit    nw;
    bit    en;
    string payload;
    bit    exp_fired;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NSID; i++) begin
      hist[i]   = "";
      hvalid[i] = 1'b0;
      m_scnt[i] = 0;
    end
    m_fires = 0;
    m_err   = 1'b0;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // A packet fires when "HTTP" ends inside its payload, given the stream's saved text tail.
  function automatic bit model_pkt(input int sid, input bit nw, input bit en, input string payload);
    string pre;
    string txt;
    bit    hit;
    pre = (nw || !hvalid[sid]) ? "" : hist[sid];
    txt = {pre, payload};
    hit = 1'b0;
    for (int i = 0; i + 4 <= txt.len(); i++)
      if ((txt.substr(i, i + 3) == "HTTP") && (i + 3 >= pre.len())) hit = 1'b1;
    if (nw) m_scnt[sid] = 0;
    if (en) begin
      hvalid[sid] = 1'b1;
      hist[sid]   = (txt.len() > 3) ? txt.substr(txt.len() - 3, txt.len() - 1) : txt;
      if (hit) begin
        m_fires++;
        m_scnt[sid]++;
      end
    end
    return en && hit;
  endfunction

  function automatic int unsigned exp_rd(input int sid, input int unsigned cap);
`ifdef CANCID_PER_STREAM_CNT_EN
    return min_u(m_scnt[sid], cap);
`else
    return (sid < 0 && cap == 0) ? 1 : 0;
`endif
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sop = 1'b0; char_vld = 1'b0; eop = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    check("rst_fired", 32'(fired), 32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("rst_sat_count", 32'(s_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // inject >= 0 drives a stray sop alongside that payload byte.
  task automatic send_pkt(input int sid, input bit nw, input bit en, input string payload,
                          input bit use_exp, input bit exp_fired, input int inject);
    bit mf;
    int lat;
    bit seen;
    mf = model_pkt(sid, nw, en, payload);
    wait_ready();
    sop = 1'b1; stream_id = SID_W'(sid); new_stream = nw; enable = en;
    @(negedge clk);
    sop = 1'b0; new_stream = 1'b0; enable = 1'b0;
    check("load_in_ready", 32'(in_ready), 32'd0);
    if (payload.len() == 0) begin
      wait_ready();
      eop = 1'b1;
      @(negedge clk);
      eop = 1'b0;
    end
    for (int i = 0; i < payload.len(); i++) begin
      wait_ready();
      char_in  = payload[i];
      char_vld = 1'b1;
      eop      = (i == payload.len() - 1);
      if (i == inject) begin
        sop        = 1'b1;
        stream_id  = SID_W'((sid + 1) % NSID);
        new_stream = 1'b1;
        m_err      = 1'b1;
      end
      @(negedge clk);
      char_vld = 1'b0; eop = 1'b0; sop = 1'b0; new_stream = 1'b0;
    end
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      if (pkt_done) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("pkt_done_latency", 32'(lat), 32'd2);
    check("fired_at_done", 32'(fired), 32'(mf));
    check("sat_fired_at_done", 32'(s_fired), 32'(mf));
    if (use_exp) check("table_fired", 32'(fired), 32'(exp_fired));
    check("commit_in_ready", 32'(in_ready), 32'd0);
    rd_sid = SID_W'(sid);
    @(negedge clk);
    check("pkt_done_pulse", 32'(pkt_done), 32'd0);
    check("fired_held", 32'(fired), 32'(mf));
    check("count", 32'(count), 32'(min_u(m_fires, 32'hFFFF)));
    check("sat_count", 32'(s_count), 32'(min_u(m_fires, 3)));
    check("proto_err", 32'(proto_err), 32'(m_err));
    @(negedge clk);
    check("rd_cnt", 32'(rd_cnt), 32'(exp_rd(sid, 32'hFFFF)));
    check("sat_rd_cnt", 32'(s_rd_cnt), 32'(exp_rd(sid, 3)));
  endtask

  function automatic void add_vec(input int sid, input bit nw, input bit en, input string p,
                                  input bit f);
    vec_t v;
    v.sid = sid; v.nw = nw; v.en = en; v.payload = p; v.exp_fired = f;
    vecs.push_back(v);
  endfunction

  initial begin
    add_vec(3, 1, 1, "GET / HTTP/1.1", 1);
    add_vec(5, 1, 1, "xxHT", 0);
    add_vec(6, 1, 1, "HTTP", 1);
    add_vec(5, 0, 1, "TPyy", 1);
    add_vec(5, 1, 1, "xxHT", 0);
    add_vec(5, 0, 0, "HTTP", 0);
    add_vec(5, 0, 1, "TPyy", 1);
    add_vec(7, 1, 1, "", 0);
    add_vec(7, 0, 1, "HTTP", 1);
    add_vec(7, 0, 1, "", 0);
    add_vec(8, 1, 1, "HHTTP", 1);
    add_vec(8, 0, 1, "HTT", 0);
    add_vec(8, 0, 1, "P", 1);
    add_vec(2, 1, 1, "HTTP", 1);
    add_vec(2, 0, 1, "xHTTP", 1);
    add_vec(2, 0, 1, "HTTPz", 1);
    add_vec(2, 1, 1, "abc", 0);

    do_reset();

    foreach (vecs[i])
      send_pkt(vecs[i].sid, vecs[i].nw, vecs[i].en, vecs[i].payload, 1'b1, vecs[i].exp_fired, -1);

    // Stray char and eop while idle: flagged, dropped, and the flag stays set.
    @(negedge clk);
    char_in = 8'h48; char_vld = 1'b1;
    @(negedge clk);
    char_vld = 1'b0; eop = 1'b1;
    @(negedge clk);
    eop   = 1'b0;
    m_err = 1'b1;
    check("err_idle_char", 32'(proto_err), 32'd1);
    send_pkt(9, 1, 1, "TTP", 1'b1, 1'b0, -1);

    // Reset in the middle of a packet on a stream with a saved "HT" tail.
    send_pkt(5, 1, 1, "xxHT", 1'b1, 1'b0, -1);
    wait_ready();
    sop = 1'b1; stream_id = SID_W'(5); new_stream = 1'b0; enable = 1'b1;
    @(negedge clk);
    sop = 1'b0;
    @(negedge clk);
    char_in = 8'h54; char_vld = 1'b1;
    @(negedge clk);
    char_vld = 1'b0;
    do_reset();
    send_pkt(5, 0, 1, "TP", 1'b1, 1'b0, -1);

    // Stray sop during RUN: flagged, the packet itself completes normally.
    send_pkt(4, 1, 1, "aHTTPb", 1'b1, 1'b1, 2);

    for (int n = 0; n < 200; n++) begin
      string p;
      int    len;
      byte   c;
      len = $urandom_range(0, 8);
      p   = "........";
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 4))
          0, 1:    c = 8'h54;
          2:       c = 8'h48;
          3:       c = 8'h50;
          default: c = 8'h78;
        endcase
        p.putc(k, c);
      end
      p = (len == 0) ? "" : p.substr(0, len - 1);
      send_pkt($urandom_range(0, 11), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
               p, 1'b0, 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
